// File: rtl/fifo_rd_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rd_arbiter
//
// Purpose
//   Drains four show-ahead FIFOs into one registered output stream. Channels
//   are granted round-robin, and each grant moves at most BURST_LEN words.
//   Each grant costs one arbitration cycle with rdreq held low.
//
// Optional feature (macro FIFO_RD_ARB_PRIO_EN)
//   When the macro is defined, channel 0 has strict priority at arbitration
//   time: it wins whenever it is non-empty. A burst that is already running
//   is never preempted. Without the macro, arbitration is pure round-robin,
//   starting at the channel after the last one granted.
//
// Parameters
//   FIFO_DATA_WIDTH  width of each channel word and of out_data
//   BURST_LEN        maximum words popped per grant (1..256)
//
// Ports
//   rdclk      in   single clock; all logic on the rising edge
//   reset      in   synchronous, active-high
//   rdempty    in   [3:0] per-channel empty flag (bit i = channel i)
//   q_bus      in   [4*W-1:0] show-ahead head words; channel i at [i*W +: W]
//   rdreq      out  [3:0] combinational pop strobe; at most one bit high
//   out_ready  in   downstream accept
//   out_valid  out  out_data/out_ch/out_sop hold a beat
//   out_data   out  [W-1:0] registered data beat
//   out_ch     out  [1:0] source channel of the current beat
//   out_sop    out  high on the first beat of each grant
//   dbg_state  out  FSM state for observation (0 = ARB, 1 = BURST)
//
// Handshake
//   A beat transfers on a rising edge where out_valid && out_ready. While
//   out_valid=1 and out_ready=0, the beat is held stable and no word is
//   popped. A pop loads the output register on the same edge that the FIFO
//   advances, so out_valid rises one cycle after rdreq.
// -----------------------------------------------------------------------------
module fifo_rd_arbiter #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int BURST_LEN       = 16
) (
  input  logic                         rdclk,
  input  logic                         reset,
  input  logic [3:0]                   rdempty,
  input  logic [4*FIFO_DATA_WIDTH-1:0] q_bus,
  output logic [3:0]                   rdreq,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [FIFO_DATA_WIDTH-1:0]   out_data,
  output logic [1:0]                   out_ch,
  output logic                         out_sop,
  output logic                         dbg_state
);

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(BURST_LEN - 1);

  state_t     state, state_nxt;
  logic [1:0] last, last_nxt;
  logic [1:0] cur, cur_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       pop;

  logic [1:0] sel;
  logic       sel_found;
  logic [1:0] probe;

  // Channel search for the next grant: the first non-empty channel at or
  // after last+1, wrapping 3->0.
  always_comb begin
    sel       = 2'd0;
    sel_found = 1'b0;
    probe     = 2'd0;
`ifdef FIFO_RD_ARB_PRIO_EN
    if (!rdempty[0]) begin
      sel       = 2'd0;
      sel_found = 1'b1;
    end
`endif
    for (int k = 1; k <= 4; k++) begin
      probe = last + 2'(k);
      if (!sel_found && !rdempty[probe]) begin
        sel       = probe;
        sel_found = 1'b1;
      end
    end
  end

  // Next-state logic and the pop strobe.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cur_nxt   = cur;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    rdreq     = 4'b0000;

    case (state)
      ARB: begin
        if (sel_found) begin
          cur_nxt   = sel;
          cnt_nxt   = 8'd0;
          state_nxt = BURST;
        end
      end

      BURST: begin
        pop        = !rdempty[cur] && (!out_valid || out_ready);
        rdreq[cur] = pop;
        if (pop) begin
          if (cnt == CNT_LAST) begin
            // Burst complete. cnt returns to 0 so it never passes BURST_LEN-1.
            cnt_nxt   = 8'd0;
            state_nxt = ARB;
            last_nxt  = cur;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end else if (rdempty[cur]) begin
          // Channel ran dry. A partial burst is normal.
          state_nxt = ARB;
          last_nxt  = cur;
        end
      end

      default: state_nxt = ARB;
    endcase

    // No FIFO may advance while reset is held, even if the FSM is in BURST.
    if (reset) begin
      pop   = 1'b0;
      rdreq = 4'b0000;
    end
  end

  always_ff @(posedge rdclk) begin
    if (reset) begin
      state     <= ARB;
      last      <= 2'd3;  // the first search after reset starts at channel 0
      cur       <= 2'd0;
      cnt       <= 8'd0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_ch    <= 2'd0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cur   <= cur_nxt;
      cnt   <= cnt_nxt;
      if (pop) begin
        out_data  <= q_bus[cur*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
        out_ch    <= cur;
        out_sop   <= (cnt == 8'd0);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign dbg_state = (state == BURST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_arbiter
//
// Self-checking bench for fifo_rd_arbiter (BURST_LEN=4, 32-bit words).
// Four queue-backed show-ahead FIFOs feed the DUT. Each scenario loads the
// FIFOs while the DUT is idle. A reference model then computes the full beat
// sequence from the grant rules: the next non-empty channel after the last
// grant (or channel 0 first when FIFO_RD_ARB_PRIO_EN is defined), and
// min(BURST_LEN, remaining) words per grant. The beat sequence does not
// depend on backpressure, so out_ready is driven freely.
// -----------------------------------------------------------------------------
module tb_fifo_rd_arbiter;
  localparam int W  = 32;
  localparam int BL = 4;
  localparam int EW = W + 3;  // {ch[1:0], sop, data}

  logic             rdclk = 1'b0;
  logic             reset;
  logic [3:0]       rdempty;
  logic [4*W-1:0]   q_bus;
  logic [3:0]       rdreq;
  logic             out_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [1:0]       out_ch;
  logic             out_sop;
  logic             dbg_state;

  // ---------------- clock / reset ----------------
  always #5 rdclk = ~rdclk;

  fifo_rd_arbiter #(
    .FIFO_DATA_WIDTH (W),
    .BURST_LEN       (BL)
  ) dut (
    .rdclk     (rdclk),
    .reset     (reset),
    .rdempty   (rdempty),
    .q_bus     (q_bus),
    .rdreq     (rdreq),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_sop   (out_sop),
    .dbg_state (dbg_state)
  );

  // ---------------- bench state ----------------
  int            errors      = 0;
  int            checks      = 0;
  int            extra_beats = 0;
  int            beats_seen  = 0;
  int            model_last  = 3;
  int            ready_mode  = 0;
  int            pat_idx     = 0;
  logic          hold_valid  = 1'b0;
  logic [EW-1:0] hold_val;
  logic [W-1:0]  fifo_q[4][$];
  logic [EW-1:0] exp_q[$];
  int            ready_pat[6] = '{1, 0, 0, 1, 0, 1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      rdempty[i]     = (fifo_q[i].size() == 0);
      q_bus[i*W +: W] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : W'($urandom);
    end
    case (ready_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2: begin
        out_ready = 1'(ready_pat[pat_idx % 6]);
        pat_idx++;
      end
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic load(input int c0, input int c1, input int c2, input int c3);
    int n[4];
    n = '{c0, c1, c2, c3};
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < n[c]; j++) fifo_q[c].push_back(W'($urandom));
  endtask

  // Reference model: the grant sequence computed directly from the rules.
  task automatic build_expected();
    int idx[4];
    int rem[4];
    int total;
    int c;
    int n;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      idx[i] = 0;
      rem[i] = fifo_q[i].size();
      total += rem[i];
    end
    while (total > 0) begin
      c = -1;
`ifdef FIFO_RD_ARB_PRIO_EN
      if (rem[0] > 0) c = 0;
`endif
      for (int k = 1; k <= 4; k++)
        if (c < 0 && rem[(model_last + k) % 4] > 0) c = (model_last + k) % 4;
      n = (rem[c] < BL) ? rem[c] : BL;
      for (int j = 0; j < n; j++) begin
        exp_q.push_back({2'(c), (j == 0), fifo_q[c][idx[c]]});
        idx[c]++;
      end
      rem[c]    -= n;
      total     -= n;
      model_last = c;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic sample();
    if (reset) begin
      check("rdreq_in_reset", 64'(rdreq), 64'd0);
    end else begin
      check("rdreq_onehot", 64'($onehot0(rdreq)), 64'd1);
      check("rdreq_nonempty", 64'(rdreq & rdempty), 64'd0);
      if (hold_valid) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_beat", 64'({out_ch, out_sop, out_data}), 64'(hold_val));
      end
      if (out_valid && out_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          extra_beats++;
          $display("FAIL unexpected_beat: got %0h expected none", {out_ch, out_sop, out_data});
        end else begin
          check("beat", 64'({out_ch, out_sop, out_data}), 64'(exp_q.pop_front()));
        end
      end
      hold_valid = out_valid && !out_ready;
      hold_val   = {out_ch, out_sop, out_data};
    end
  endtask

  // One clock. Outputs are sampled at the falling edge, FIFO pops are applied
  // just after the rising edge, and new inputs are driven right after that.
  task automatic step();
    logic [3:0] rq;
    @(negedge rdclk);
    sample();
    rq = rdreq;
    @(posedge rdclk);
    #1;
    for (int i = 0; i < 4; i++)
      if (rq[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
    drive_inputs();
  endtask

  task automatic drain(input string tag);
    int n;
    int left;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 800) begin
      step();
      n++;
    end
    left = 0;
    for (int i = 0; i < 4; i++) left += fifo_q[i].size();
    check({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_fifo_left"}, 64'(left), 64'd0);
  endtask

  task automatic run(input string tag, input int c0, input int c1, input int c2,
                     input int c3, input int mode);
    ready_mode = mode;
    load(c0, c1, c2, c3);
    build_expected();
    drive_inputs();
    drain(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset     = 1'b1;
    out_ready = 1'b1;
    rdempty   = 4'hF;
    q_bus     = '0;
    repeat (3) @(posedge rdclk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sop",   64'(out_sop),   64'd0);
    check("rst_ch",    64'(out_ch),    64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_rdreq", 64'(rdreq),     64'd0);
    reset = 1'b0;
    drive_inputs();

    // All channels empty: nothing moves.
    repeat (20) begin
      step();
      check("idle_state", 64'(dbg_state), 64'd0);
      check("idle_valid", 64'(out_valid), 64'd0);
      check("idle_rdreq", 64'(rdreq),     64'd0);
    end

    run("ch1_only",  0, 10, 0, 0, 0);
    run("all_eight", 8, 8, 8, 8, 0);
    run("ch2_toggle", 0, 0, 3, 0, 2);
    run("ch0_ch3",   5, 0, 0, 5, 1);
    run("stall_one", 0, 0, 0, 6, 1);
    for (int r = 0; r < 6; r++)
      run("random", $urandom_range(0, 12), $urandom_range(0, 12),
          $urandom_range(0, 12), $urandom_range(0, 12), 1);

    // Reset on the second beat of a burst on ch2.
    ready_mode = 0;
    beats_seen = 0;
    load(0, 0, 6, 2);
    build_expected();
    drive_inputs();
    n = 0;
    while (beats_seen < 2 && n < 100) begin
      step();
      n++;
    end
    check("mid_burst_reached", 64'(beats_seen >= 2), 64'd1);
    reset = 1'b1;
    step();
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'd0);
    step();
    reset      = 1'b0;
    hold_valid = 1'b0;
    exp_q.delete();
    model_last = 3;
    build_expected();
    drive_inputs();
    drain("after_reset");

    check("extra_beats", 64'(extra_beats), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
